cache_fill_fsm: RTL and testbench

- Miss-handling controller for the cache data/tag arrays.
- On a cache miss it fetches the whole 16-byte block from pipelined memory as 8 sequential 16-bit words.
- For each returned word it drives the word offset and data into the data-array write path, which feeds the word/bit-select mux tree.
- On the last word it also writes the tag array.

---
 rtl/cache_fill_fsm.sv | 128 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Purpose : cache miss fill controller; fetches a 16-byte block as 8 words and writes the data/tag arrays.
// Latency : first read request one cycle after miss acceptance; tag write coincides with the 8th returned word.
// Backpress: none on memory returns (every valid in FILL is consumed); fsm_busy stalls the pipeline during a fill.
//
// Ports:
//   clk, rst_n         - rising-edge clock, asynchronous active-low reset
//   miss_detected      - miss strobe, only looked at while idle
//   miss_address       - byte address of the missing access
//   memory_data_valid  - a returned word is present on memory_data
//   memory_data        - returned word, in the order the reads were issued
//   fsm_busy           - high for the whole fill (pipeline stall)
//   mem_read           - read request this cycle, at memory_address
//   memory_address     - block base plus byte offset of the requested word
//   write_data_array   - write fill_data into the data array at word_offset
//   write_tag_array    - write the tag of the block being filled
//   word_offset        - word index within the block for the data write
//   fill_data          - word to write (pass-through of memory_data)

module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int OFF_W  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [ADDR_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [OFF_W-1:0]  word_offset,
  output logic [ADDR_W-1:0] fill_data
);

  // Counters need one extra bit so they can hold WORDS itself (saturated / done).
  localparam int CNT_W = OFF_W + 1;
  // Words are two bytes, so the byte offset inside a block is one bit wider than the word offset.
  localparam int BYTE_OFF_W = OFF_W + 1;

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BYTE_OFF_W) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt, issue_cnt_nxt;
  logic [CNT_W-1:0]  recv_cnt, recv_cnt_nxt;
  logic [ADDR_W-1:0] base, base_nxt;

  // State register. Reset drops any fill in flight; no tag is written for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_cnt_nxt;
      recv_cnt  <= recv_cnt_nxt;
      base      <= base_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt        = state;
    issue_cnt_nxt    = issue_cnt;
    recv_cnt_nxt     = recv_cnt;
    base_nxt         = base;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_offset      = '0;
    fill_data        = '0;

    case (state)
      IDLE: begin
        // Returns arriving while idle are not ours; they are dropped.
        if (miss_detected) begin
          base_nxt      = miss_address & BLOCK_MASK;
          issue_cnt_nxt = '0;
          recv_cnt_nxt  = '0;
          state_nxt     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        // Issue side: one request per cycle until all words are requested.
        // base has a zero low nibble, so the add never carries into tag bits.
        if (issue_cnt < CNT_FULL) begin
          mem_read       = 1'b1;
          memory_address = base + ADDR_W'({issue_cnt[OFF_W-1:0], 1'b0});
          issue_cnt_nxt  = issue_cnt + 1'b1;
        end

        // Receive side runs independently of issue; returns are in order,
        // so the receive count is the word offset.
        if (memory_data_valid && (recv_cnt < CNT_FULL)) begin
          write_data_array = 1'b1;
          word_offset      = recv_cnt[OFF_W-1:0];
          fill_data        = memory_data;
          recv_cnt_nxt     = recv_cnt + 1'b1;
          // Last word: the block is complete, so the tag goes in alongside it.
          if (recv_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Purpose : randomized self-checking bench for cache_fill_fsm against a queue-based reference model.
// Latency : outputs compared every cycle at the falling edge, inputs driven just after the rising edge.
// Backpress: memory returns are scheduled from the model's issued requests with a random latency/gap.

module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_offset;
  logic [15:0] fill_data;

  cache_fill_fsm #(.WORDS(8), .OFF_W(3), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_offset       (word_offset),
    .fill_data         (fill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a fill is "8 request addresses to hand out" plus "count of words received".
  typedef struct {
    int          t;
    logic [15:0] d;
  } ret_t;

  bit          in_fill;
  logic [15:0] req_q[$];
  ret_t        ret_q[$];
  int          words_recv;
  int          nreq;
  int          last_ret;
  int          cyc;
  int          wr_seen;

  // Memory behaviour knobs for the current fill.
  int          lat;
  int          gmax;
  logic [15:0] data_base;
  bit          noise;
  bit          rnd_miss;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_rd"},   mem_read, 0);
    chk({tag, "_addr"}, memory_address, 0);
    chk({tag, "_wr"},   write_data_array, 0);
    chk({tag, "_tag"},  write_tag_array, 0);
    chk({tag, "_off"},  word_offset, 0);
    chk({tag, "_data"}, fill_data, 0);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic miss, input logic [15:0] maddr);
    logic        exp_rd, exp_wr, exp_tag;
    logic [15:0] exp_addr, exp_data;
    logic [2:0]  exp_off;
    ret_t        r;
    int          t;

    miss_detected = miss;
    miss_address  = maddr;
    if (ret_q.size() > 0 && ret_q[0].t <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = ret_q[0].d;
      void'(ret_q.pop_front());
    end else if (noise && !in_fill) begin
      memory_data_valid = 1'($urandom_range(1, 0));
      memory_data       = 16'hFFFF;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end

    @(negedge clk);
    exp_rd   = in_fill && (req_q.size() > 0);
    exp_addr = exp_rd ? req_q[0] : 16'h0;
    exp_wr   = in_fill && memory_data_valid;
    exp_off  = exp_wr ? 3'(words_recv) : 3'h0;
    exp_data = exp_wr ? memory_data : 16'h0;
    exp_tag  = exp_wr && (words_recv == 7);

    chk("busy",  fsm_busy,         in_fill);
    chk("rd",    mem_read,         exp_rd);
    chk("addr",  memory_address,   exp_addr);
    chk("wr",    write_data_array, exp_wr);
    chk("off",   word_offset,      exp_off);
    chk("data",  fill_data,        exp_data);
    chk("tag",   write_tag_array,  exp_tag);
    if (write_data_array) wr_seen++;

    if (rst_n) begin
      if (in_fill) begin
        if (exp_rd) begin
          void'(req_q.pop_front());
          t = cyc + lat;
          if (last_ret + 1 + int'($urandom_range(gmax, 0)) > t)
            t = last_ret + 1 + int'($urandom_range(gmax, 0));
          if (t <= last_ret) t = last_ret + 1;
          last_ret = t;
          r.t = t;
          r.d = 16'(data_base + 16'(nreq));
          ret_q.push_back(r);
          nreq++;
        end
        if (exp_wr) begin
          words_recv++;
          if (words_recv == 8) in_fill = 1'b0;
        end
      end else if (miss) begin
        in_fill    = 1'b1;
        words_recv = 0;
        nreq       = 0;
        last_ret   = cyc;
        req_q.delete();
        for (int k = 0; k < 8; k++) req_q.push_back((maddr & 16'hFFF0) + 16'(2 * k));
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Accept a miss, then run until the model says the fill is over (or abort by reset).
  task automatic run_fill(input logic [15:0] addr, input int ign_at, input int abort_after);
    int  k;
    bit  aborted;
    wr_seen = 0;
    aborted = 0;
    step(1'b1, addr);
    k = 0;
    while (in_fill && k < 300) begin
      if (k == ign_at)
        step(1'b1, 16'h8000);
      else
        step(rnd_miss ? 1'($urandom_range(1, 0)) : 1'b0, 16'($urandom));
      k++;
      if (abort_after > 0 && words_recv == abort_after && in_fill) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        in_fill = 1'b0;
        req_q.delete();
        ret_q.delete();
        #1;
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        rst_n = 1'b1;
        step(1'b0, 16'h0);
        chk("rst_mid_writes", wr_seen, abort_after);
        aborted = 1;
        break;
      end
    end
    chk("fill_done", in_fill, 0);
    if (!aborted) chk("fill_writes", wr_seen, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    in_fill = 0; words_recv = 0; nreq = 0; last_ret = 0; wr_seen = 0;
    lat = 4; gmax = 0; data_base = 16'hA000; noise = 0; rnd_miss = 0;
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = 16'h0;
    memory_data_valid = 1'b0;
    memory_data = 16'h0;

    // Reset state, with stray returns and misses held off.
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    rst_n = 1'b1;

    // Idle with noisy valids carrying 0xFFFF: nothing must be written.
    noise = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0);

    // Basic fill: fixed latency 4, data 0xA000+offset.
    lat = 4; gmax = 0; data_base = 16'hA000;
    run_fill(16'h1236, -1, 0);
    step(1'b0, 16'h0);

    // Gapped returns.
    lat = 1; gmax = 3; data_base = 16'($urandom);
    run_fill(16'h1236, -1, 0);

    // Miss while busy is ignored; a miss on the first idle cycle starts the next fill.
    lat = 2; gmax = 1; data_base = 16'h5100;
    run_fill(16'h1230, 3, 0);
    data_base = 16'h8800;
    run_fill(16'h8000, -1, 0);
    step(1'b0, 16'h0);

    // Reset after 3 returned words, then a fresh fill from 0x4440.
    lat = 3; gmax = 2; data_base = 16'h3300;
    run_fill(16'h1230, -1, 3);
    data_base = 16'h4400;
    run_fill(16'h4440, -1, 0);

    // Top-of-memory block: no carry beyond 0xFFFE.
    lat = 5; gmax = 0; data_base = 16'hF0F0;
    run_fill(16'hFFFF, -1, 0);

    // Random fills with random idle gaps, stray valids and stray misses.
    rnd_miss = 1;
    for (int n = 0; n < 12; n++) begin
      lat       = int'($urandom_range(6, 1));
      gmax      = int'($urandom_range(3, 0));
      data_base = 16'($urandom);
      run_fill(16'($urandom), -1, 0);
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) step(1'b0, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
